// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: turns 5-byte serial packets into NCO phase-increment
// updates, either as a fixed value or as an autonomous linear sweep with a
// programmable per-step dwell time.
module nco_sweep_ctrl #(
    parameter int unsigned TIMEOUT   = 1000000,
    parameter logic [31:0] INIT_INCR = 32'h0000_0000,
    parameter int unsigned DWELL_W   = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_byte,
    input  logic        rbyte_ready,
    input  logic        tick,
    output logic [31:0] angle_incr,
    output logic        incr_upd,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic        pkt_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] A_FIXED = 3'd0;
    localparam logic [2:0] A_START = 3'd1;
    localparam logic [2:0] A_STOP  = 3'd2;
    localparam logic [2:0] A_STEP  = 3'd3;
    localparam logic [2:0] A_DWELL = 3'd4;
    localparam logic [2:0] A_CTRL  = 3'd5;

    typedef enum logic {P_HDR, P_DATA} pstate_t;
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP} sstate_t;

    pstate_t            p_state, p_next;
    sstate_t            s_state, s_next;

    logic [6:0]         hdr_r;
    logic [2:0][6:0]    dat_r;
    logic [1:0]         byte_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic               wr_stb;
    logic [2:0]         wr_addr;
    logic [31:0]        wr_word;

    logic [31:0]        start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r, dwell_cnt, dwell_eff;
    logic               loop_r;

    logic               is_hdr, to_hit, err_now, commit_now;
    logic               wr_fixed, wr_ctrl, in_range;
    logic [32:0]        next_sum;

    // ---------------- parser FSM ----------------

    // Parser state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) p_state <= P_HDR;
        else         p_state <= p_next;
    end

    // Parser next state: a header byte always (re)starts a packet
    always_comb begin
        p_next = p_state;
        case (p_state)
            P_HDR:  if (rbyte_ready && is_hdr) p_next = P_DATA;
            P_DATA: begin
                if (rbyte_ready) begin
                    if (!is_hdr && byte_cnt == 2'd3) p_next = P_HDR;
                end else if (to_hit) begin
                    p_next = P_HDR;
                end
            end
            default: p_next = P_HDR;
        endcase
    end

    // Parser decoded events
    always_comb begin
        is_hdr     = rx_byte[7];
        to_hit     = (p_state == P_DATA) && !rbyte_ready && (to_cnt == TO_W'(TIMEOUT - 1));
        err_now    = (rbyte_ready && (p_state == P_HDR) && !is_hdr) ||
                     (rbyte_ready && (p_state == P_DATA) && is_hdr) || to_hit;
        commit_now = (p_state == P_DATA) && rbyte_ready && !is_hdr && (byte_cnt == 2'd3);
    end

    // Byte capture, inter-byte timeout and the registered write strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hdr_r    <= '0;
            dat_r    <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_word  <= '0;
        end else begin
            if (rbyte_ready && is_hdr) begin
                hdr_r    <= rx_byte[6:0];
                byte_cnt <= '0;
            end else if (rbyte_ready && p_state == P_DATA) begin
                case (byte_cnt)
                    2'd0:    dat_r[0] <= rx_byte[6:0];
                    2'd1:    dat_r[1] <= rx_byte[6:0];
                    2'd2:    dat_r[2] <= rx_byte[6:0];
                    default: ;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (rbyte_ready || p_state != P_DATA) to_cnt <= '0;
            else                                  to_cnt <= to_cnt + TO_W'(1);
            wr_stb <= commit_now;
            if (commit_now) begin
                wr_addr <= hdr_r[6:4];
                // 4th data byte is still on rx_byte this cycle
                wr_word <= {hdr_r[3], rx_byte[6:0], hdr_r[2], dat_r[2],
                            hdr_r[1], dat_r[1], hdr_r[0], dat_r[0]};
            end
        end
    end

    // ---------------- sweep FSM ----------------

    // Sweep decode: FIXED/CTRL writes override any sweep activity
    always_comb begin
        wr_fixed  = wr_stb && (wr_addr == A_FIXED);
        wr_ctrl   = wr_stb && (wr_addr == A_CTRL);
        dwell_eff = (dwell_r == '0) ? DWELL_W'(1) : dwell_r;
        next_sum  = {1'b0, angle_incr} + {1'b0, step_r};
        in_range  = !next_sum[32] && (next_sum[31:0] <= stop_r);
    end

    // Sweep state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) s_state <= S_IDLE;
        else         s_state <= s_next;
    end

    // Sweep next state
    always_comb begin
        s_next = s_state;
        if (wr_fixed) begin
            s_next = S_IDLE;
        end else if (wr_ctrl) begin
            s_next = wr_word[0] ? S_DWELL : S_IDLE;
        end else begin
            case (s_state)
                S_DWELL: if (tick && dwell_cnt == DWELL_W'(1)) s_next = S_STEP;
                S_STEP:  s_next = (in_range || loop_r) ? S_DWELL : S_IDLE;
                default: s_next = S_IDLE;
            endcase
        end
    end

    // Sweep outputs
    always_comb begin
        sweep_busy = (s_state != S_IDLE);
    end

    // Register file, dwell counter, increment and pulse outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_r    <= '0;
            stop_r     <= '0;
            step_r     <= '0;
            dwell_r    <= DWELL_W'(1);
            loop_r     <= 1'b0;
            dwell_cnt  <= '0;
            angle_incr <= INIT_INCR;
            incr_upd   <= 1'b0;
            sweep_done <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            incr_upd   <= 1'b0;
            sweep_done <= 1'b0;
            // Unmapped addresses 6/7 report at commit time
            pkt_err    <= err_now || (wr_stb && wr_addr[2:1] == 2'b11);
            if (wr_stb) begin
                case (wr_addr)
                    A_START: start_r <= wr_word;
                    A_STOP:  stop_r  <= wr_word;
                    A_STEP:  step_r  <= wr_word;
                    A_DWELL: dwell_r <= wr_word[DWELL_W-1:0];
                    A_CTRL:  loop_r  <= wr_word[1];
                    default: ;
                endcase
            end
            if (wr_fixed) begin
                angle_incr <= wr_word;
                incr_upd   <= 1'b1;
            end else if (wr_ctrl) begin
                if (wr_word[0]) begin
                    angle_incr <= start_r;
                    incr_upd   <= 1'b1;
                    dwell_cnt  <= dwell_eff;
                end
            end else begin
                case (s_state)
                    S_DWELL: if (tick) dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    S_STEP: begin
                        if (in_range) begin
                            angle_incr <= next_sum[31:0];
                            incr_upd   <= 1'b1;
                            dwell_cnt  <= dwell_eff;
                        end else if (loop_r) begin
                            angle_incr <= start_r;
                            incr_upd   <= 1'b1;
                            dwell_cnt  <= dwell_eff;
                        end else begin
                            sweep_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: fixed writes, sweeps (plain, looping,
// carry), protocol errors, timeout and asynchronous reset.
module tb_nco_sweep_ctrl;

    localparam logic [31:0] INIT = 32'hA5A5_0001;

    logic        clk;
    logic        resetn;
    logic [7:0]  rx_byte;
    logic        rbyte_ready;
    logic        tick;
    logic [31:0] angle_incr;
    logic        incr_upd, sweep_busy, sweep_done, pkt_err;

    int n_tests = 0;
    int n_fail  = 0;

    nco_sweep_ctrl #(.TIMEOUT(20), .INIT_INCR(INIT), .DWELL_W(24)) dut (
        .clk(clk), .resetn(resetn), .rx_byte(rx_byte), .rbyte_ready(rbyte_ready),
        .tick(tick), .angle_incr(angle_incr), .incr_upd(incr_upd),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .pkt_err(pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte     = b;
        rbyte_ready = 1'b1;
        cyc();
        rbyte_ready = 1'b0;
        rx_byte     = 8'h00;
    endtask

    function automatic logic [7:0] hdr_byte(input logic [2:0] a, input logic [31:0] w);
        return {1'b1, a, w[31], w[23], w[15], w[7]};
    endfunction

    function automatic logic [7:0] dat_byte(input logic [31:0] w, input int i);
        return {1'b0, w[8*i +: 7]};
    endfunction

    // Returns in the cycle after the last byte was sampled (write strobe cycle)
    task automatic send_pkt(input logic [2:0] a, input logic [31:0] w);
        send_byte(hdr_byte(a, w));
        for (int i = 0; i < 4; i++) send_byte(dat_byte(w, i));
    endtask

    logic [31:0] vals [4];

    initial begin
        resetn = 1'b1; rx_byte = 8'h00; rbyte_ready = 1'b0; tick = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rst_incr", angle_incr, INIT);
        check("rst_upd",  {31'b0, incr_upd},   0);
        check("rst_busy", {31'b0, sweep_busy}, 0);
        check("rst_done", {31'b0, sweep_done}, 0);
        check("rst_err",  {31'b0, pkt_err},    0);
        #19 resetn = 1'b1;
        cyc();
        cyc();
        check("post_rst_incr", angle_incr, INIT);

        // FIXED write: one incr_upd, two cycles after the last byte
        send_pkt(3'd0, 32'h1234_5678);
        check("fix_upd_early", {31'b0, incr_upd}, 0);
        cyc();
        check("fix_incr", angle_incr, 32'h1234_5678);
        check("fix_upd",  {31'b0, incr_upd}, 1);
        cyc();
        check("fix_upd_once", {31'b0, incr_upd}, 0);

        // Non-looping sweep 100..400 step 100, DWELL=3, tick always on.
        // Each value lasts DWELL tick cycles plus the one-cycle step state.
        tick = 1'b1;
        send_pkt(3'd1, 32'd100);
        send_pkt(3'd2, 32'd400);
        send_pkt(3'd3, 32'd100);
        send_pkt(3'd4, 32'd3);
        send_pkt(3'd5, 32'd1);
        cyc();
        check("sw_first", angle_incr, 32'd100);
        check("sw_first_upd", {31'b0, incr_upd}, 1);
        check("sw_busy", {31'b0, sweep_busy}, 1);
        repeat (3) cyc();
        check("sw_hold", angle_incr, 32'd100);
        check("sw_hold_upd", {31'b0, incr_upd}, 0);
        cyc();
        check("sw_200", angle_incr, 32'd200);
        check("sw_200_upd", {31'b0, incr_upd}, 1);
        repeat (4) cyc();
        check("sw_300", angle_incr, 32'd300);
        repeat (4) cyc();
        check("sw_400", angle_incr, 32'd400);
        check("sw_400_done", {31'b0, sweep_done}, 0);
        repeat (4) cyc();
        check("sw_done", {31'b0, sweep_done}, 1);
        check("sw_end_busy", {31'b0, sweep_busy}, 0);
        check("sw_end_incr", angle_incr, 32'd400);
        check("sw_end_upd", {31'b0, incr_upd}, 0);
        cyc();
        check("sw_done_once", {31'b0, sweep_done}, 0);

        // Looping sweep: wraps to START with no done pulse, then abort
        vals[0] = 32'd200; vals[1] = 32'd300; vals[2] = 32'd400; vals[3] = 32'd100;
        send_pkt(3'd5, 32'd3);
        cyc();
        check("lp_first", angle_incr, 32'd100);
        for (int i = 0; i < 4; i++) begin
            repeat (4) cyc();
            check("lp_seq", angle_incr, vals[i]);
            check("lp_seq_upd", {31'b0, incr_upd}, 1);
        end
        check("lp_no_done", {31'b0, sweep_done}, 0);
        check("lp_busy", {31'b0, sweep_busy}, 1);
        // Sweep continues during the abort packet: 200 appears, then abort lands
        send_pkt(3'd5, 32'd0);
        cyc();
        check("ab_busy", {31'b0, sweep_busy}, 0);
        check("ab_incr", angle_incr, 32'd200);
        check("ab_upd",  {31'b0, incr_upd}, 0);
        repeat (8) cyc();
        check("ab_frozen", angle_incr, 32'd200);
        check("ab_no_done", {31'b0, sweep_done}, 0);

        // 33-bit carry ends the sweep even though the wrapped sum is <= STOP
        send_pkt(3'd1, 32'hFFFF_FF00);
        send_pkt(3'd2, 32'hFFFF_FFFF);
        send_pkt(3'd3, 32'h0000_0200);
        send_pkt(3'd5, 32'd1);
        cyc();
        check("cy_start", angle_incr, 32'hFFFF_FF00);
        repeat (4) cyc();
        check("cy_done", {31'b0, sweep_done}, 1);
        check("cy_incr", angle_incr, 32'hFFFF_FF00);
        check("cy_busy", {31'b0, sweep_busy}, 0);

        // Header interrupting a packet: one error, second packet applied
        send_byte(hdr_byte(3'd0, 32'h1111_1111));
        send_byte(dat_byte(32'h1111_1111, 0));
        send_byte(dat_byte(32'h1111_1111, 1));
        check("rs_no_err", {31'b0, pkt_err}, 0);
        send_byte(hdr_byte(3'd0, 32'h0BAD_F00D));
        check("rs_err", {31'b0, pkt_err}, 1);
        for (int i = 0; i < 4; i++) begin
            send_byte(dat_byte(32'h0BAD_F00D, i));
            if (i == 0) check("rs_err_once", {31'b0, pkt_err}, 0);
        end
        cyc();
        check("rs_incr", angle_incr, 32'h0BAD_F00D);
        check("rs_upd",  {31'b0, incr_upd}, 1);

        // Timeout after header + 1 byte (TIMEOUT=20)
        send_byte(hdr_byte(3'd0, 32'h55));
        send_byte(dat_byte(32'h55, 0));
        repeat (19) cyc();
        check("to_not_yet", {31'b0, pkt_err}, 0);
        cyc();
        check("to_err", {31'b0, pkt_err}, 1);
        cyc();
        check("to_err_once", {31'b0, pkt_err}, 0);
        // Back in P_HDR: a data byte is an error and changes nothing
        send_byte(8'h22);
        check("hdr_data_err", {31'b0, pkt_err}, 1);
        check("hdr_data_upd", {31'b0, incr_upd}, 0);
        cyc();
        check("hdr_data_incr", angle_incr, 32'h0BAD_F00D);

        // Unmapped address 6
        send_pkt(3'd6, 32'h0000_DEAD);
        cyc();
        check("a6_err",  {31'b0, pkt_err}, 1);
        check("a6_upd",  {31'b0, incr_upd}, 0);
        check("a6_incr", angle_incr, 32'h0BAD_F00D);

        // Asynchronous reset during a looping sweep
        send_pkt(3'd1, 32'd100);
        send_pkt(3'd5, 32'd3);
        repeat (6) cyc();
        check("ar_busy_before", {31'b0, sweep_busy}, 1);
        resetn = 1'b0;
        #1;
        check("ar_incr", angle_incr, INIT);
        check("ar_busy", {31'b0, sweep_busy}, 0);
        #2 resetn = 1'b1;
        cyc();
        check("ar_incr_after", angle_incr, INIT);

        // After reset START=STOP=STEP=0, DWELL=1: value held, upd every expiry
        send_pkt(3'd5, 32'd1);
        cyc();
        check("z_incr", angle_incr, 32'd0);
        check("z_upd",  {31'b0, incr_upd}, 1);
        cyc();
        check("z_upd_gap", {31'b0, incr_upd}, 0);
        cyc();
        check("z_upd_again", {31'b0, incr_upd}, 1);
        check("z_incr_held", angle_incr, 32'd0);
        check("z_busy", {31'b0, sweep_busy}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
